keypad_code_lock: RTL

- Consumer end of the membrane keypad scanner's key-code stream.
- Takes the scanner's one-cycle key codes:
  - 0-9 are digits
  - 10 is hash/enter
  - 11 is star
  - 13 is no command
- Assembles a PIN, compares it against the stored code and drives the safe's unlock, bad-attempt and lockout indications.
- Also re-programs the code while open.
- Sits between the keypad scanner and the bolt/indicator logic.

---
 rtl/keypad_code_lock.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/keypad_code_lock.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_code_lock : PIN entry, compare, lockout and re-programming FSM    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module keypad_code_lock #(
   parameter int                  DIGITS         = 4,
   parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
   parameter int                  MAX_FAILS      = 3,
   parameter int                  LOCKOUT_CYCLES = 1000,
   parameter int                  IDLE_TIMEOUT   = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code,
   input  logic       lock_cmd,
   output logic       unlocked,
   output logic       bad_attempt,
   output logic       code_changed,
   output logic       locked_out,
   output logic [2:0] digit_count
);

   localparam int c_TMR_MAX = (LOCKOUT_CYCLES > IDLE_TIMEOUT) ? LOCKOUT_CYCLES : IDLE_TIMEOUT;
   localparam int c_TW      = $clog2(c_TMR_MAX + 1);
   localparam int c_FW      = $clog2(MAX_FAILS + 1);

   localparam logic [c_TW-1:0] c_IDLE_LAST = c_TW'(IDLE_TIMEOUT - 1);
   localparam logic [c_TW-1:0] c_IDLE_STOP = c_TW'(IDLE_TIMEOUT);
   localparam logic [c_TW-1:0] c_LOCK_INIT = c_TW'(LOCKOUT_CYCLES);
   localparam logic [c_FW-1:0] c_FAIL_LAST = c_FW'(MAX_FAILS - 1);
   localparam logic [c_FW-1:0] c_FAIL_MAX  = c_FW'(MAX_FAILS);
   localparam logic [2:0]      c_DIGITS    = 3'(DIGITS);

   typedef enum logic [1:0] {
      S_LOCKED  = 2'd0,
      S_CHECK   = 2'd1,
      S_OPEN    = 2'd2,
      S_LOCKOUT = 2'd3
   } state_t;

   state_t                r_state;
   logic [4*DIGITS-1:0]   r_code;
   logic [4*DIGITS-1:0]   r_buf;
   logic [2:0]            r_cnt;
   logic                  r_ovf;
   logic [c_FW-1:0]       r_fails;
   logic [c_TW-1:0]       r_idle;
   logic [c_TW-1:0]       r_lock;

   logic w_key_ev, w_digit, w_star, w_full, w_empty, w_match;

   assign w_key_ev = (key_code <= 4'd11);
   assign w_digit  = (key_code <= 4'd9);
   assign w_star   = (key_code == 4'd11);
   assign w_full   = (r_cnt == c_DIGITS) && !r_ovf;
   assign w_empty  = (r_cnt == 3'd0) && !r_ovf;
   assign w_match  = w_full && (r_buf == r_code);

   assign digit_count = r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_LOCKED;
         r_code       <= DEFAULT_CODE;
         r_buf        <= '0;
         r_cnt        <= '0;
         r_ovf        <= 1'b0;
         r_fails      <= '0;
         r_idle       <= '0;
         r_lock       <= '0;
         unlocked     <= 1'b0;
         bad_attempt  <= 1'b0;
         code_changed <= 1'b0;
         locked_out   <= 1'b0;
      end else begin
         bad_attempt  <= 1'b0;
         code_changed <= 1'b0;
         case (r_state)
            S_LOCKED, S_OPEN: begin
               // relock request wins over any key arriving in the same cycle
               if (r_state == S_OPEN && lock_cmd) begin
                  r_state  <= S_LOCKED;
                  unlocked <= 1'b0;
                  r_buf    <= '0;
                  r_cnt    <= '0;
                  r_ovf    <= 1'b0;
                  r_idle   <= '0;
               end else if (w_key_ev) begin
                  r_idle <= '0;
                  if (w_digit) begin
                     if (r_cnt < c_DIGITS) begin
                        r_buf <= {r_buf[4*DIGITS-5:0], key_code};
                        r_cnt <= r_cnt + 3'd1;
                     end else begin
                        r_ovf <= 1'b1;
                     end
                  end else if (w_star) begin
                     r_buf <= '0;
                     r_cnt <= '0;
                     r_ovf <= 1'b0;
                  end else if (r_state == S_LOCKED) begin
                     r_state <= S_CHECK;
                  end else begin
                     r_buf <= '0;
                     r_cnt <= '0;
                     r_ovf <= 1'b0;
                     if (w_full) begin
                        r_code       <= r_buf;
                        code_changed <= 1'b1;
                     end else if (w_empty) begin
                        r_state  <= S_LOCKED;
                        unlocked <= 1'b0;
                     end else begin
                        bad_attempt <= 1'b1;
                     end
                  end
               end else if (r_idle == c_IDLE_LAST) begin
                  r_buf <= '0;
                  r_cnt <= '0;
                  r_ovf <= 1'b0;
                  if (r_state == S_OPEN) begin
                     r_state  <= S_LOCKED;
                     unlocked <= 1'b0;
                     r_idle   <= '0;
                  end else begin
                     r_idle <= c_IDLE_STOP;
                  end
               end else if (r_idle != c_IDLE_STOP) begin
                  r_idle <= r_idle + c_TW'(1);
               end
            end

            S_CHECK: begin
               r_buf  <= '0;
               r_cnt  <= '0;
               r_ovf  <= 1'b0;
               r_idle <= '0;
               if (w_match) begin
                  r_state  <= S_OPEN;
                  unlocked <= 1'b1;
                  r_fails  <= '0;
               end else begin
                  bad_attempt <= 1'b1;
                  if (r_fails >= c_FAIL_LAST) begin
                     r_state    <= S_LOCKOUT;
                     locked_out <= 1'b1;
                     r_lock     <= c_LOCK_INIT;
                     r_fails    <= c_FAIL_MAX;
                  end else begin
                     r_state <= S_LOCKED;
                     r_fails <= r_fails + c_FW'(1);
                  end
               end
            end

            S_LOCKOUT: begin
               // leave on the edge where the countdown hits zero
               if (r_lock <= c_TW'(1)) begin
                  r_lock     <= '0;
                  r_state    <= S_LOCKED;
                  locked_out <= 1'b0;
                  r_fails    <= '0;
                  r_idle     <= '0;
               end else begin
                  r_lock <= r_lock - c_TW'(1);
               end
            end

            default: begin
               r_state <= S_LOCKED;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
